// File: rtl/cve2_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : cve2_pkg
// Brief   : Shared types for the cve2 memory arbiter slice.
// Revision: 1.0
// ----------------------------------------------------------------------------
package cve2_pkg;

   typedef enum logic {
      ARB_SRC_INSTR = 1'b0,
      ARB_SRC_DATA  = 1'b1
   } arb_src_e;

endpackage
`default_nettype wire

// File: rtl/cve2_arb_id_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : cve2_arb_id_fifo
// Brief   : Small in-order FIFO holding the source ID of each outstanding txn.
// Revision: 1.0
// ----------------------------------------------------------------------------
module cve2_arb_id_fifo #(
   parameter int unsigned Depth = 2,
   parameter int unsigned Width = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             pop_i,
   output logic [Width-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);
   localparam logic [PtrW-1:0] c_last_ptr = PtrW'(Depth - 1);
   localparam logic [CntW-1:0] c_full_cnt = CntW'(Depth);

   // Storage is rounded up to a power of two so pointer indexing is always in range.
   logic [Width-1:0] r_mem [2**PtrW];
   logic [PtrW-1:0]  r_wptr;
   logic [PtrW-1:0]  r_rptr;
   logic [CntW-1:0]  r_cnt;
   logic             w_push;
   logic             w_pop;

   assign full_o  = (r_cnt == c_full_cnt);
   assign empty_o = (r_cnt == '0);
   assign w_push  = push_i & ~full_o;
   assign w_pop   = pop_i & ~empty_o;
   assign data_o  = r_mem[r_rptr];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push) r_wptr <= (r_wptr == c_last_ptr) ? '0 : r_wptr + PtrW'(1);
         if (w_pop)  r_rptr <= (r_rptr == c_last_ptr) ? '0 : r_rptr + PtrW'(1);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + CntW'(1);
            2'b01:   r_cnt <= r_cnt - CntW'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wptr] <= data_i;
   end

endmodule
`default_nettype wire

// File: rtl/cve2_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : cve2_mem_arbiter
// Brief   : Merges instruction-fetch and LSU ports onto one shared memory port.
// Revision: 1.0
// ----------------------------------------------------------------------------
module cve2_mem_arbiter
   import cve2_pkg::*;
#(
   parameter int unsigned MaxOutstanding = 2,
   parameter bit          RoundRobin     = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        instr_req_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   input  logic [31:0] instr_addr_i,
   output logic [31:0] instr_rdata_o,
   output logic        instr_err_o,
   input  logic        data_req_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,
   output logic        bus_req_o,
   input  logic        bus_gnt_i,
   input  logic        bus_rvalid_i,
   output logic        bus_we_o,
   output logic [3:0]  bus_be_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_wdata_o,
   input  logic [31:0] bus_rdata_i,
   input  logic        bus_err_i,
   output logic        idle_o
);

   arb_src_e   w_sel;
   arb_src_e   w_head;
   arb_src_e   r_lock_sel;
   arb_src_e   r_last;
   logic       r_locked;
   logic       w_sel_req;
   logic       w_hs;
   logic       w_pop;
   logic       w_full;
   logic       w_empty;
   logic [0:0] w_head_raw;

   // A request offered but not yet granted keeps its owner until the handshake.
   always_comb begin
      w_sel = ARB_SRC_INSTR;
      if (r_locked) begin
         w_sel = r_lock_sel;
      end else if (instr_req_i && data_req_i) begin
         if (RoundRobin) w_sel = (r_last == ARB_SRC_INSTR) ? ARB_SRC_DATA : ARB_SRC_INSTR;
         else            w_sel = ARB_SRC_DATA;
      end else if (data_req_i) begin
         w_sel = ARB_SRC_DATA;
      end
   end

   assign w_sel_req   = (w_sel == ARB_SRC_DATA) ? data_req_i : instr_req_i;
   assign bus_req_o   = w_sel_req & ~w_full;
   assign w_hs        = bus_req_o & bus_gnt_i;
   assign instr_gnt_o = w_hs & (w_sel == ARB_SRC_INSTR);
   assign data_gnt_o  = w_hs & (w_sel == ARB_SRC_DATA);

   assign bus_we_o    = (w_sel == ARB_SRC_DATA) ? data_we_i    : 1'b0;
   assign bus_be_o    = (w_sel == ARB_SRC_DATA) ? data_be_i    : 4'hF;
   assign bus_addr_o  = (w_sel == ARB_SRC_DATA) ? data_addr_i  : instr_addr_i;
   assign bus_wdata_o = (w_sel == ARB_SRC_DATA) ? data_wdata_i : 32'h0;

   cve2_arb_id_fifo #(
      .Depth (MaxOutstanding),
      .Width (1)
   ) u_id_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (w_hs),
      .data_i  (w_sel),
      .pop_i   (w_pop),
      .data_o  (w_head_raw),
      .full_o  (w_full),
      .empty_o (w_empty)
   );

   // Responses with nothing outstanding are dropped rather than routed.
   assign w_head         = arb_src_e'(w_head_raw);
   assign w_pop          = bus_rvalid_i & ~w_empty;
   assign instr_rvalid_o = w_pop & (w_head == ARB_SRC_INSTR);
   assign data_rvalid_o  = w_pop & (w_head == ARB_SRC_DATA);
   assign instr_rdata_o  = bus_rdata_i;
   assign data_rdata_o   = bus_rdata_i;
   assign instr_err_o    = bus_err_i;
   assign data_err_o     = bus_err_i;
   assign idle_o         = w_empty & ~instr_req_i & ~data_req_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_locked   <= 1'b0;
         r_lock_sel <= ARB_SRC_INSTR;
         r_last     <= ARB_SRC_INSTR;
      end else begin
         r_locked   <= bus_req_o & ~bus_gnt_i;
         r_lock_sel <= w_sel;
         if (w_hs) r_last <= w_sel;
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk_i) begin
      if (rst_ni) begin
         assert (!(bus_rvalid_i && w_empty))
            else $warning("cve2_mem_arbiter: bus_rvalid_i with no outstanding transaction");
      end
   end
`endif

endmodule
`default_nettype wire
